// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-file port arbiter.
package reg_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, REJECT} state_t;

  localparam int REG_ADDR_W    = 6;
  localparam int REG_DATA_W    = 8;
  localparam int NUM_REGS_DEF  = 37;
  localparam int ADC_FIRST_DEF = 3;
  localparam int ADC_LAST_DEF  = 5;

  // Out-of-range addresses and writes into the read-only ADC window never reach the register file.
  function automatic logic is_illegal(logic [REG_ADDR_W-1:0] addr, logic we,
                                      int num_regs, int adc_first, int adc_last);
    int a;
    a = int'(addr);
    return (a >= num_regs) || (we && (a >= adc_first) && (a <= adc_last));
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side handshake plus the register-file port, bundled for the arbiter.
interface reg_bus_arbiter_if
  import reg_bus_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]                 req;
  logic [N_REQ-1:0]                 we;
  logic [N_REQ-1:0][REG_ADDR_W-1:0] addr;
  logic [N_REQ-1:0][REG_DATA_W-1:0] wdata;
  logic [N_REQ-1:0]                 gnt;
  logic [N_REQ-1:0]                 done;
  logic                             err;
  logic [REG_DATA_W-1:0]            rdata;
  logic [REG_ADDR_W-1:0]            mem_addr;
  logic [REG_DATA_W-1:0]            mem_wdata;
  logic                             mem_write;
  logic                             mem_read;
  logic [REG_DATA_W-1:0]            mem_rdata;

  modport master (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, err, rdata, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, err, rdata, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/reg_bus_arbiter_rr.sv
// Round-robin pick: first set bit of cand searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win_oh
);
  always_comb begin
    logic found;
    int   idx;
    win_oh = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && cand[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sequencing access/recover timing onto the analog-control register file.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ADC_FIRST   = ADC_FIRST_DEF,
  parameter int ADC_LAST    = ADC_LAST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bus_arbiter_if.master bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t                  state;
  logic [PTR_W-1:0]        ptr, win_q, win_idx;
  logic [CNT_W-1:0]        cnt;
  logic                    we_q;
  logic [N_REQ-1:0]        gnt_r, done_r, cand, win_oh;
  logic                    err_r, mem_read_r, mem_write_r, win_ill;
  logic [REG_DATA_W-1:0]   rdata_r, mem_wdata_r;
  logic [REG_ADDR_W-1:0]   mem_addr_r;

  // A held req is masked while its own transfer is still granted or just completed.
  assign cand = bus.req & ~gnt_r & ~done_r;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .cand   (cand),
    .ptr    (ptr),
    .win_oh (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_oh[i]) win_idx = PTR_W'(i);
  end

  assign win_ill = is_illegal(bus.addr[win_idx], bus.we[win_idx], NUM_REGS, ADC_FIRST, ADC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= PTR_W'(N_REQ - 1);
      win_q       <= '0;
      cnt         <= '0;
      we_q        <= 1'b0;
      gnt_r       <= '0;
      done_r      <= '0;
      err_r       <= 1'b0;
      rdata_r     <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      case (state)
        IDLE: if (|cand) begin
          gnt_r <= win_oh;
          ptr   <= win_idx;
          win_q <= win_idx;
          we_q  <= bus.we[win_idx];
          if (win_ill) begin
            state <= REJECT;
          end else begin
            state       <= ACCESS;
            cnt         <= '0;
            mem_addr_r  <= bus.addr[win_idx];
            mem_wdata_r <= bus.wdata[win_idx];
            mem_write_r <= bus.we[win_idx];
            mem_read_r  <= !bus.we[win_idx];
          end
        end
        ACCESS: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            state       <= RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Idle clock lets the register file's negedge enable logic re-arm.
        RECOVER: begin
          if (!we_q) rdata_r <= bus.mem_rdata;
          done_r[win_q] <= 1'b1;
          gnt_r         <= '0;
          state         <= IDLE;
        end
        REJECT: begin
          done_r[win_q] <= 1'b1;
          err_r         <= 1'b1;
          gnt_r         <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Shares the single register port of the analog-control register file (37 x 8-bit registers, 6-bit address) between N_REQ requesters, e.g. the I2C slave and an on-chip calibration/scan sequencer.
- Arbitration is round-robin.
- Each granted transfer is sequenced with the access/recovery timing the register file requires: control held for ≥2 clocks, then one idle clock so its negedge enable logic re-arms.
- Illegal accesses are rejected before they reach the register file: writes to ADC registers 3–5, and any address > 36.

Parameters:
N_REQ, 2, number of requesters (2..8)
HOLD_CYCLES, 2, clocks mem_read/mem_write held per transfer (min 2)
NUM_REGS, 37, valid addresses 0..NUM_REGS-1
ADC_FIRST, 3, first read-only register
ADC_LAST, 5, last read-only register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester request, level
we  in  N_REQ  1 = write, 0 = read
addr  in  6*N_REQ  packed register addresses, requester i at [6i+:6]
wdata  in  8*N_REQ  packed write data, requester i at [8i+:8]
gnt  out  N_REQ  one-hot, high while requester's transfer owns the bus
done  out  N_REQ  1-clock completion pulse
err  out  1  qualifies done: transfer rejected
rdata  out  8  read data, valid with done of a successful read
mem_addr  out  6  to register file address
mem_wdata  out  8  to register file write data
mem_write  out  1  to register file write enable
mem_read  out  1  to register file read enable
mem_rdata  in  8  from register file registered data out

Behaviour:
- Reset (async): state IDLE, all outputs 0, RR pointer = N_REQ-1 (so requester 0 wins first). Reset mid-transfer drops mem_read/mem_write immediately; no done is issued.
- States: IDLE, ACCESS, RECOVER, REJECT.
- IDLE:
  - Candidate = req[i] && !gnt[i] && !done[i].
  - If any candidate exists, winner = first candidate searching from pointer+1 with wrap. Latch winner's we/addr/wdata, set gnt[winner], pointer = winner.
  - Legal winner → ACCESS. Illegal (addr ≥ NUM_REGS, or we && ADC_FIRST ≤ addr ≤ ADC_LAST) → REJECT.
- ACCESS, HOLD_CYCLES clocks:
  - mem_addr/mem_wdata = latched values; mem_write = we; mem_read = !we. Never both high.
  - After the last hold clock → RECOVER.
- RECOVER, 1 clock:
  - mem_read = mem_write = 0; mem_addr/mem_wdata hold.
  - At the closing edge: for reads rdata <= mem_rdata (else rdata unchanged); done[winner] <= 1, err <= 0, gnt <= 0; → IDLE.
- REJECT, 1 clock: no mem activity. At the closing edge: done[winner] <= 1, err <= 1, gnt <= 0; → IDLE.
- Latency, req sampled at edge 0:
  - Legal: done high in clock HOLD_CYCLES+2 (4 by default).
  - Illegal: done high in clock 2.
- Back-to-back: a new grant may be taken in the same clock done is high. Bus issue rate is one transfer per HOLD_CYCLES+2 clocks.
- Requester protocol:
  - Requester holds req/we/addr/wdata stable until gnt rises, then may drop req.
  - req is ignored while that requester's gnt or done is high, so a held req is never double-served within one transfer.
- Simultaneous requests are served strictly round-robin. A requester that keeps req asserted waits at most N_REQ-1 transfers.
- done, err and gnt are registered outputs; rdata holds its value until the next successful read completes.

Decomposition:
- reg_bus_pkg:
  - state enum (IDLE, ACCESS, RECOVER, REJECT)
  - REG_ADDR_W = 6, REG_DATA_W = 8
  - NUM_REGS/ADC_FIRST/ADC_LAST default constants
  - function is_illegal(addr, we)
- Sub-module rr_arbiter (N-bit round-robin priority pick from req mask + pointer; combinational one-hot output) is natural and reusable.

Test Plan:
1. Reset, then req[0] read addr 7 (memory preloaded 8'hA5) → gnt[0] from clock 1; mem_read high clocks 1–2; low clock 3; done[0]=1, err=0, rdata=8'hA5 in clock 4.
2. req[1] write addr 4, data 8'h3C → no mem_write ever; done[1]=1, err=1 in clock 2; reg 4 still tracks ADC_in[1].
3. req[0] and req[1] asserted together and held, both writing addr 10 with 8'h11 / 8'h22 → serve order 0, 1, 0, 1; each done spaced 4 clocks apart; reg 10 reads back 8'h22 after the second transfer.
4. req[0] read addr 40 → err=1, no mem_read; then req[0] read addr 36 (preloaded 8'h5A) → err=0, rdata=8'h5A.
5. rst_n low during clock 2 of a write → mem_write drops asynchronously; gnt, done and err are 0; after release, req[1] wins first only if req[0] is idle, and req[0] wins a tie.
6. Write addr 0 = 8'h47, then read addr 0 → rdata 8'h47; Amp_EN[0]=1, Timer_FEN[0]=0, CS_control[0]=3'b111 after the recovery clock.
